if_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the MIPS core, replacing the single-cycle `pc`-only fetch. It owns the PC, issues word requests to an instruction memory with variable latency over a request/grant plus in-order response interface, buffers returned words in a small FIFO, and hands them to decode with a valid/ready handshake. Jump, taken-branch and jump-register redirects flush the buffer and discard in-flight responses.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/if_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: data widths, the redirect-kind encoding and
// the immediate sign-extension helper.
package mips_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    NONE,
    BR,
    J,
    JR
  } redir_e;

  // Sign-extend a 16-bit immediate to 64 bits; callers size-cast to their width.
  function automatic logic [63:0] sext16to(input logic [15:0] value);
    return {{48{value[15]}}, value};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with show-ahead output taken straight from the
// storage flops (no write-to-read bypass), synchronous clear and occupancy count.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal when a pop frees the head slot in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_MAX) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every always_ff sees pre-edge values.
    if (!init_n || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited requests to a
// variable-latency instruction memory and buffers in-order responses for decode.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              j,
  input  logic              branch,
  input  logic              zero,
  input  logic              jr,
  input  logic [PC_W-1:0]   src_pc,
  input  logic [25:0]       target,
  input  logic [15:0]       imm,
  input  logic [PC_W-1:0]   jr_addr,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = PC_W + INST_W;
  localparam logic [PC_W-1:0]  WORD    = PC_W'(4);
  localparam logic [PC_W-1:0]  ALIGN   = ~PC_W'(3);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(DEPTH);

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    seq;
  logic [PC_W-1:0]    j_pc;
  logic [PC_W-1:0]    br_pc;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    tag;
  logic [ENTRY_W-1:0] entry;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   tag_count;
  redir_e             kind;
  logic               redirect;
  logic               credit_ok;
  logic               grant;
  logic               drop;
  logic               accept;
  logic               pop;

  assign seq   = src_pc + WORD;
  assign br_pc = seq + (PC_W'(sext16to(imm)) << 2);

  generate
    if (PC_W > 28) begin : g_j_region
      assign j_pc = {seq[PC_W-1:28], target, 2'b00};
    end else begin : g_j_flat
      assign j_pc = {target, 2'b00};
    end
  endgenerate

  always_comb begin
    // NOTE: default first so every path assigns; a missing branch would infer a latch.
    kind = NONE;
    if (jr)                  kind = JR;
    else if (j)              kind = J;
    else if (branch && zero) kind = BR;
  end

  always_comb begin
    redirect_pc = pc;
    unique case (kind)
      JR:      redirect_pc = jr_addr;
      J:       redirect_pc = j_pc;
      BR:      redirect_pc = br_pc;
      default: redirect_pc = pc;
    endcase
  end

  assign redirect  = (kind != NONE);
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS;
  assign imem_req  = credit_ok && !redirect && init_n;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  // Responses owed to a flushed stream have no tag; an untagged live response is ignored.
  assign drop   = imem_rvalid && (drop_cnt != '0);
  assign accept = imem_rvalid && !drop && !redirect && (tag_count != '0);

  assign inst_valid = (fifo_count != '0) && !redirect;
  assign pop        = inst_valid && inst_ready;
  assign inst       = entry[INST_W-1:0];
  assign inst_pc    = entry[ENTRY_W-1:INST_W];

  always_ff @(posedge clk) begin
    if (!init_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect)   pc <= redirect_pc & ALIGN;
      else if (grant) pc <= pc + WORD;

      if (grant && !imem_rvalid)      outstanding <= outstanding + CNT_ONE;
      else if (!grant && imem_rvalid) outstanding <= outstanding - CNT_ONE;

      if (redirect)  drop_cnt <= outstanding - CNT_W'(imem_rvalid);
      else if (drop) drop_cnt <= drop_cnt - CNT_ONE;
    end
  end

  fetch_fifo #(
    .WIDTH(PC_W),
    .DEPTH(DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .init_n(init_n),
    .clr   (redirect),
    .push  (grant),
    .wdata (pc),
    .pop   (accept),
    .rdata (tag),
    .count (tag_count)
  );

  fetch_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_inst_q (
    .clk   (clk),
    .init_n(init_n),
    .clr   (redirect),
    .push  (accept),
    .wdata ({tag, imem_rdata}),
    .pop   (pop),
    .rdata (entry),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: redirect-target table, hand-written
// corner sequences and a randomized run against a stream-level reference model.
module tb_if_fetch_unit;

  localparam int          PC_W     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        j = 1'b0, branch = 1'b0, zero = 1'b0, jr = 1'b0;
  logic [31:0] src_pc = '0, jr_addr = '0;
  logic [25:0] target = '0;
  logic [15:0] imm = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;

  if_fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .init_n(init_n), .j(j), .branch(branch), .zero(zero), .jr(jr),
    .src_pc(src_pc), .target(target), .imm(imm), .jr_addr(jr_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  // Reference model: requests in flight at the memory (tagged with the fetch
  // stream they belong to) and addresses buffered for decode, in order.
  typedef struct { logic [31:0] addr; int due; int epoch; } pend_t;
  pend_t       pending[$];
  logic [31:0] buf_q[$];
  logic [31:0] exp_addr = RESET_PC;
  int          epoch = 0, cyc = 0, pops = 0;
  int          errors = 0, checks = 0;

  int k_gnt = 100, k_ready = 100, k_rv = 100, k_lat_min = 1, k_lat_max = 1;
  bit k_random = 1'b0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  typedef struct {
    logic jr, j, br, zero;
    logic [31:0] src;
    logic [25:0] tgt;
    logic [15:0] imm;
    logic [31:0] jra;
    logic exp_redir;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[10];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_target();
    logic [31:0] s;
    int off;
    s = src_pc + 32'd4;
    if (jr) return jr_addr & ~32'd3;
    if (j) return (s & 32'hF000_0000) | ({6'd0, target} << 2);
    off = int'($signed(imm)) * 4;
    return s + 32'(off);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clear_redir();
    jr = 1'b0; j = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step();
    pend_t       h;
    logic        rv, redir, exp_req, exp_valid, hot;
    logic [31:0] tgt, r;
    int          lat;
    if (k_random) begin
      init_n = ($urandom_range(499, 0) != 0);
      r = $urandom;
      hot = (r[11:8] == 4'd0);
      jr = hot & r[0]; j = hot & r[1]; branch = r[2]; zero = hot & r[3];
      src_pc = $urandom & ~32'd3; target = 26'($urandom);
      imm = 16'($urandom); jr_addr = $urandom;
    end
    rv = init_n && (pending.size() > 0) && ($urandom_range(99, 0) < k_rv);
    if (rv) rv = (pending[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pending[0].addr) : $urandom;
    imem_gnt    = ($urandom_range(99, 0) < k_gnt);
    inst_ready  = ($urandom_range(99, 0) < k_ready);
    #3;
    redir     = jr | j | (branch & zero);
    tgt       = ref_target();
    exp_req   = init_n && !redir && ((pending.size() + buf_q.size()) < DEPTH);
    exp_valid = !redir && (buf_q.size() > 0);
    check("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", 64'(imem_addr), 64'(exp_addr));
    check("inst_valid", 64'(inst_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("inst_pc", 64'(inst_pc), 64'(buf_q[0]));
      check("inst", 64'(inst), 64'(mem_word(buf_q[0])));
    end
    s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid; s_pc = inst_pc;
    if (!init_n) begin
      pending.delete();
      buf_q.delete();
      exp_addr = RESET_PC;
    end else begin
      if (rv) begin
        h = pending.pop_front();
        if (h.epoch == epoch && !redir) buf_q.push_back(h.addr);
      end
      if (exp_valid && inst_ready) begin
        void'(buf_q.pop_front());
        pops++;
      end
      if (exp_req && imem_gnt) begin
        lat = $urandom_range(k_lat_max, k_lat_min);
        pending.push_back('{addr: exp_addr, due: cyc + lat, epoch: epoch});
        exp_addr = exp_addr + 32'd4;
      end
      if (redir) begin
        epoch++;
        buf_q.delete();
        exp_addr = tgt;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    clear_redir();
    init_n = 1'b0;
    step();
    step();
    init_n = 1'b1;
  endtask

  task automatic set_mem(input int gnt, input int lat, input int ready);
    k_gnt = gnt; k_lat_min = lat; k_lat_max = lat; k_ready = ready; k_rv = 100;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int n = 0;
    while (!s_valid && n < 40) begin
      step();
      n++;
    end
    check({name, " valid"}, 64'(s_valid), 64'(1));
    check({name, " first inst_pc"}, 64'(s_pc), 64'(exp_pc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0] = '{1, 1, 0, 0, 32'h0,         26'h0,       16'h0,    32'h1003,      1, 32'h1000};
    vecs[1] = '{0, 1, 0, 0, 32'hF000_0000, 26'h1,       16'h0,    32'h0,         1, 32'hF000_0004};
    vecs[2] = '{0, 0, 1, 1, 32'h10,        26'h0,       16'hFFFE, 32'h0,         1, 32'h0C};
    vecs[3] = '{0, 0, 1, 0, 32'h10,        26'h0,       16'hFFFE, 32'h0,         0, 32'h0};
    vecs[4] = '{0, 1, 1, 1, 32'h100,       26'h3FF_FFFF, 16'h0010, 32'h0,        1, 32'h0FFF_FFFC};
    vecs[5] = '{0, 0, 1, 1, 32'hFFFF_FFF8, 26'h0,       16'h0001, 32'h0,         1, 32'h0};
    vecs[6] = '{1, 0, 1, 1, 32'h40,        26'h0,       16'h0,    32'hFFFF_FFFF, 1, 32'hFFFF_FFFC};
    vecs[7] = '{0, 0, 1, 1, 32'h0,         26'h0,       16'h7FFF, 32'h0,         1, 32'h0002_0000};
    vecs[8] = '{0, 1, 0, 0, 32'h0FFF_FFFC, 26'h0,       16'h0,    32'h0,         1, 32'h1000_0000};
    vecs[9] = '{0, 0, 0, 1, 32'h10,        26'h0,       16'hFFFE, 32'h0,         0, 32'h0};

    @(posedge clk);
    #1;

    // Reset and first fetch: one request per cycle, first instruction two cycles later.
    set_mem(100, 1, 100);
    reset_seq();
    check("reset imem_req", 64'(s_req), 64'(0));
    check("reset imem_addr", 64'(s_addr), 64'(RESET_PC));
    check("reset inst_valid", 64'(s_valid), 64'(0));
    step();
    check("c0 req", 64'(s_req), 64'(1));
    check("c0 addr", 64'(s_addr), 64'(32'h0));
    step();
    check("c1 addr", 64'(s_addr), 64'(32'h4));
    check("c1 valid", 64'(s_valid), 64'(0));
    step();
    check("c2 addr", 64'(s_addr), 64'(32'h8));
    check("c2 valid", 64'(s_valid), 64'(1));
    check("c2 inst_pc", 64'(s_pc), 64'(32'h0));
    step();
    check("c3 inst_pc", 64'(s_pc), 64'(32'h4));

    // Backpressure: requests stop at full credit, then four pops drain in order.
    k_ready = 0;
    repeat (8) step();
    check("bp req dropped", 64'(s_req), 64'(0));
    check("bp valid held", 64'(s_valid), 64'(1));
    k_gnt = 0;
    k_ready = 100;
    p0 = pops;
    repeat (4) step();
    check("bp pops", 64'(pops - p0), 64'(4));

    // Redirect target and priority table.
    foreach (vecs[i]) begin
      set_mem(0, 1, 100);
      reset_seq();
      jr = vecs[i].jr; j = vecs[i].j; branch = vecs[i].br; zero = vecs[i].zero;
      src_pc = vecs[i].src; target = vecs[i].tgt; imm = vecs[i].imm; jr_addr = vecs[i].jra;
      step();
      check($sformatf("vec%0d req", i), 64'(s_req), 64'(!vecs[i].exp_redir));
      clear_redir();
      step();
      check($sformatf("vec%0d next addr", i), 64'(s_addr), 64'(vecs[i].exp_addr));
    end

    // Taken branch with three requests in flight, memory latency four.
    set_mem(100, 4, 100);
    reset_seq();
    repeat (3) step();
    branch = 1'b1; zero = 1'b1; src_pc = 32'h10; imm = 16'hFFFE;
    step();
    check("br cycle req", 64'(s_req), 64'(0));
    clear_redir();
    step();
    check("br target addr", 64'(s_addr), 64'(32'h0C));
    wait_valid("br", 32'h0C);

    // Redirect in the same cycle as a response: that response is also dropped.
    set_mem(100, 4, 100);
    reset_seq();
    repeat (4) step();
    jr = 1'b1; jr_addr = 32'h200;
    step();
    clear_redir();
    wait_valid("redir+resp", 32'h200);

    // Mid-operation reset with two buffered and two outstanding.
    set_mem(100, 3, 0);
    reset_seq();
    repeat (5) step();
    init_n = 1'b0;
    step();
    init_n = 1'b1;
    step();
    check("midrst valid", 64'(s_valid), 64'(0));
    check("midrst req", 64'(s_req), 64'(1));
    check("midrst addr", 64'(s_addr), 64'(RESET_PC));

    // PC wrap-around at the top of the address space.
    set_mem(0, 1, 100);
    reset_seq();
    jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
    step();
    clear_redir();
    set_mem(100, 1, 100);
    step();
    check("wrap addr hi", 64'(s_addr), 64'(32'hFFFF_FFFC));
    step();
    check("wrap addr lo", 64'(s_addr), 64'(32'h0));
    wait_valid("wrap", 32'hFFFF_FFFC);

    // Randomized traffic, redirects and resets against the model.
    p0 = pops;
    k_random = 1'b1;
    for (int blk = 0; blk < 15; blk++) begin
      k_gnt = $urandom_range(100, 30);
      k_ready = $urandom_range(100, 20);
      k_rv = $urandom_range(100, 30);
      k_lat_min = 1;
      k_lat_max = $urandom_range(6, 1);
      repeat (200) step();
    end
    k_random = 1'b0;
    clear_redir();
    init_n = 1'b1;
    set_mem(100, 1, 100);
    repeat (40) step();
    check("random throughput", 64'(pops - p0 > 300), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
